instr_predecode_queue: RTL and testbench

Parametrised instruction queue between fetch and the decoder. Each accepted instruction is predecoded once at write time: branch/jump class, branch condition, sign-extended control-flow offset, and legality. The predecode is stored beside the instruction and PC. Presents a registered valid/ready stream to the decode stage, with single-cycle flush for redirects and interrupts.

---
 rtl/instr_predecode_queue.sv | 234 +++++++++++++++++++++++
 tb/tb_instr_predecode_queue.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_predecode_queue.sv
// -----------------------------------------------------------------------------
// instr_predecode_queue
//
// Circular instruction queue sitting between fetch and decode. Every accepted
// instruction is predecoded once, at write time, and the result is stored next
// to the raw instruction and its PC, so the decoder sees the class flags,
// branch condition, sign-extended offset and legality straight from storage.
//
// Optional build feature (macro PREDECODE_TARGET_EN):
//   defined   - each B-type / JAL entry also stores pc + imm, presented on
//               out_target_o for the head; all other entries store 0.
//   undefined - no adder, no target storage, out_target_o is tied to 0.
//   The port list is identical in both builds.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. in_ready_o and out_valid_o are functions of
// registered occupancy only, so neither depends combinationally on
// in_valid_i or out_ready_i. There is no empty bypass: a pushed entry is
// visible on the output one cycle after the push edge at the earliest.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   flush_i          drop every entry; pushes/pops in the same cycle are lost
//   in_valid_i       fetch presents in_instr_i / in_pc_i
//   in_ready_o       queue has room (count < DEPTH)
//   in_instr_i       raw RV32 instruction
//   in_pc_i          PC of in_instr_i
//   out_valid_o      head entry valid (count != 0)
//   out_ready_i      decoder consumes head this cycle
//   out_instr_o      head instruction
//   out_pc_o         head PC
//   out_is_branch_o  head is B-type
//   out_is_jal_o     head is JAL
//   out_is_jalr_o    head is JALR
//   out_br_cond_o    funct3 of head when B-type, else 0
//   out_imm_o        sign-extended B/J/I offset for branch/JAL/JALR, else 0
//   out_illegal_o    head failed the legality check
//   count_o          current occupancy
//   out_target_o     stored pc + imm for head (feature build), else 0
// -----------------------------------------------------------------------------
module instr_predecode_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_instr_i,
  input  logic [XLEN-1:0]  in_pc_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_instr_o,
  output logic [XLEN-1:0]  out_pc_o,
  output logic             out_is_branch_o,
  output logic             out_is_jal_o,
  output logic             out_is_jalr_o,
  output logic [2:0]       out_br_cond_o,
  output logic [31:0]      out_imm_o,
  output logic             out_illegal_o,
  output logic [CNT_W-1:0] count_o,
  output logic [XLEN-1:0]  out_target_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // One stored queue entry: raw fields plus predecode results.
  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic [2:0]      br_cond;
    logic [31:0]     imm;
    logic            illegal;
`ifdef PREDECODE_TARGET_EN
    logic [XLEN-1:0] target;
`endif
  } entry_t;

  // ---------------------------------------------------------------------------
  // Predecode of the incoming instruction (combinational, stored at push)
  // ---------------------------------------------------------------------------
  logic [6:0]  pd_opcode;
  logic [2:0]  pd_funct3;
  logic        pd_is_branch;
  logic        pd_is_jal;
  logic        pd_is_jalr;
  logic        pd_opcode_known;
  logic        pd_illegal;
  logic [31:0] pd_imm;
  logic [2:0]  pd_br_cond;

  assign pd_opcode    = in_instr_i[6:0];
  assign pd_funct3    = in_instr_i[14:12];
  // Class flags follow the opcode alone; legality is reported separately.
  assign pd_is_branch = (pd_opcode == OP_BRANCH);
  assign pd_is_jal    = (pd_opcode == OP_JAL);
  assign pd_is_jalr   = (pd_opcode == OP_JALR);
  assign pd_br_cond   = pd_is_branch ? pd_funct3 : 3'b000;

  always_comb begin
    pd_opcode_known = 1'b0;
    case (pd_opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
      OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM: pd_opcode_known = 1'b1;
      default:                                       pd_opcode_known = 1'b0;
    endcase
  end

  // Compressed encodings (low bits != 11) are not supported here.
  assign pd_illegal = (in_instr_i[1:0] != 2'b11)
                    | !pd_opcode_known
                    | (pd_is_jalr & (pd_funct3 != 3'b000))
                    | (pd_is_branch & ((pd_funct3 == 3'b010) | (pd_funct3 == 3'b011)));

  always_comb begin
    pd_imm = 32'd0;
    if (pd_is_branch) begin
      pd_imm = {{19{in_instr_i[31]}}, in_instr_i[31], in_instr_i[7],
                in_instr_i[30:25], in_instr_i[11:8], 1'b0};
    end else if (pd_is_jal) begin
      pd_imm = {{11{in_instr_i[31]}}, in_instr_i[31], in_instr_i[19:12],
                in_instr_i[20], in_instr_i[30:21], 1'b0};
    end else if (pd_is_jalr) begin
      pd_imm = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
    end
  end

`ifdef PREDECODE_TARGET_EN
  logic [XLEN-1:0] pd_imm_x;
  logic [XLEN-1:0] pd_target;

  // Offset sign-extended (or truncated) to XLEN; the add wraps mod 2^XLEN.
  assign pd_imm_x  = XLEN'($signed(pd_imm));
  assign pd_target = (pd_is_branch | pd_is_jal) ? (in_pc_i + pd_imm_x) : '0;
`endif

  entry_t wr_entry;

  always_comb begin
    wr_entry           = '0;
    wr_entry.instr     = in_instr_i;
    wr_entry.pc        = in_pc_i;
    wr_entry.is_branch = pd_is_branch;
    wr_entry.is_jal    = pd_is_jal;
    wr_entry.is_jalr   = pd_is_jalr;
    wr_entry.br_cond   = pd_br_cond;
    wr_entry.imm       = pd_imm;
    wr_entry.illegal   = pd_illegal;
`ifdef PREDECODE_TARGET_EN
    wr_entry.target    = pd_target;
`endif
  end

  // ---------------------------------------------------------------------------
  // Queue control
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  assign in_ready_o  = (count < FULL_CNT);
  assign out_valid_o = (count != '0);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  assign count_o     = count;

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; entries are only observed while counted valid.
  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (push && !rst && !flush_i) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Head outputs, straight from storage at the read pointer
  // ---------------------------------------------------------------------------
  entry_t head;

  assign head            = mem[rd_ptr];
  assign out_instr_o     = head.instr;
  assign out_pc_o        = head.pc;
  assign out_is_branch_o = head.is_branch;
  assign out_is_jal_o    = head.is_jal;
  assign out_is_jalr_o   = head.is_jalr;
  assign out_br_cond_o   = head.br_cond;
  assign out_imm_o       = head.imm;
  assign out_illegal_o   = head.illegal;

`ifdef PREDECODE_TARGET_EN
  assign out_target_o = head.target;
`else
  assign out_target_o = '0;
`endif

endmodule

// File: tb/tb_instr_predecode_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_predecode_queue
//
// Directed bench for instr_predecode_queue (DEPTH=4, XLEN=32). Inputs are
// driven 1 time unit after each rising edge and outputs are sampled there,
// well away from the next active edge. Expected values are hand-computed
// from the instruction encodings.
// -----------------------------------------------------------------------------
module tb_instr_predecode_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      in_instr_i;
  logic [XLEN-1:0]  in_pc_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [31:0]      out_instr_o;
  logic [XLEN-1:0]  out_pc_o;
  logic             out_is_branch_o;
  logic             out_is_jal_o;
  logic             out_is_jalr_o;
  logic [2:0]       out_br_cond_o;
  logic [31:0]      out_imm_o;
  logic             out_illegal_o;
  logic [CNT_W-1:0] count_o;
  logic [XLEN-1:0]  out_target_o;

  instr_predecode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush_i         (flush_i),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .in_instr_i      (in_instr_i),
    .in_pc_i         (in_pc_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_instr_o     (out_instr_o),
    .out_pc_o        (out_pc_o),
    .out_is_branch_o (out_is_branch_o),
    .out_is_jal_o    (out_is_jal_o),
    .out_is_jalr_o   (out_is_jalr_o),
    .out_br_cond_o   (out_br_cond_o),
    .out_imm_o       (out_imm_o),
    .out_illegal_o   (out_illegal_o),
    .count_o         (count_o),
    .out_target_o    (out_target_o)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_asserts = 0;
  int n_fail    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc, input logic br,
                            input logic jal, input logic jalr,
                            input logic [2:0] cond, input logic [31:0] imm,
                            input logic ill, input logic [31:0] tgt);
    chk({tag, ".valid"},  32'(out_valid_o), 32'd1);
    chk({tag, ".instr"},  out_instr_o, instr);
    chk({tag, ".pc"},     out_pc_o, pc);
    chk({tag, ".class"},  32'({out_is_branch_o, out_is_jal_o, out_is_jalr_o}),
                          32'({br, jal, jalr}));
    chk({tag, ".cond"},   32'(out_br_cond_o), 32'(cond));
    chk({tag, ".imm"},    out_imm_o, imm);
    chk({tag, ".illegal"}, 32'(out_illegal_o), 32'(ill));
`ifdef PREDECODE_TARGET_EN
    chk({tag, ".target"}, out_target_o, tgt);
`else
    chk({tag, ".target"}, out_target_o, 32'd0);
`endif
  endtask

  task automatic check_status(input string tag, input int cnt, input logic vld,
                              input logic rdy);
    chk({tag, ".count"},    32'(count_o), 32'(cnt));
    chk({tag, ".out_valid"}, 32'(out_valid_o), 32'(vld));
    chk({tag, ".in_ready"}, 32'(in_ready_o), 32'(rdy));
  endtask

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
    in_valid_i = 1'b1;
    in_instr_i = instr;
    in_pc_i    = pc;
    step();
    in_valid_i = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst         = 1'b1;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    in_instr_i  = 32'd0;
    in_pc_i     = '0;
    out_ready_i = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_status("reset", 0, 1'b0, 1'b1);

    // addi x1,x0,4 at PC 0 with the decoder ready: visible one cycle later.
    out_ready_i = 1'b1;
    push_one(32'h00400093, 32'h0);
    check_status("addi", 1, 1'b1, 1'b1);
    check_head("addi", 32'h00400093, 32'h0, 0, 0, 0, 3'd0, 32'h0, 0, 32'h0);
    step();
    check_status("addi_pop", 0, 1'b0, 1'b1);

    // Fill with four branches (beq/bne/blt/bgeu, offset -4), decoder stalled.
    out_ready_i = 1'b0;
    push_one(32'hfe628ee3, 32'h10);
    push_one(32'hfe629ee3, 32'h14);
    push_one(32'hfe62cee3, 32'h18);
    push_one(32'hfe62fee3, 32'h1C);
    check_status("full", 4, 1'b1, 1'b0);
    check_head("br0", 32'hfe628ee3, 32'h10, 1, 0, 0, 3'b000, 32'hFFFFFFFC, 0, 32'h0C);

    // Fifth instruction offered while full and stalled: held, head stable.
    in_valid_i = 1'b1;
    in_instr_i = 32'h00500113;
    in_pc_i    = 32'h20;
    step();
    check_status("full_hold", 4, 1'b1, 1'b0);
    check_head("br0_stable", 32'hfe628ee3, 32'h10, 1, 0, 0, 3'b000, 32'hFFFFFFFC, 0, 32'h0C);

    // Pop while full: no push that cycle.
    out_ready_i = 1'b1;
    step();
    check_status("pop_full", 3, 1'b1, 1'b1);
    check_head("br1", 32'hfe629ee3, 32'h14, 1, 0, 0, 3'b001, 32'hFFFFFFFC, 0, 32'h10);
    step();  // X5 pushed, br1 popped
    in_instr_i = 32'h00600193;
    in_pc_i    = 32'h24;
    check_status("pushpop1", 3, 1'b1, 1'b1);
    check_head("br2", 32'hfe62cee3, 32'h18, 1, 0, 0, 3'b100, 32'hFFFFFFFC, 0, 32'h14);
    step();  // X6 pushed
    in_instr_i = 32'h008000EF;  // jal x1,+8
    in_pc_i    = 32'h28;
    check_head("br3", 32'hfe62fee3, 32'h1C, 1, 0, 0, 3'b111, 32'hFFFFFFFC, 0, 32'h18);
    step();  // X7 pushed
    in_instr_i = 32'h00800293;
    in_pc_i    = 32'h2C;
    check_head("x5", 32'h00500113, 32'h20, 0, 0, 0, 3'd0, 32'h0, 0, 32'h0);
    step();  // X8 pushed
    in_valid_i = 1'b0;
    check_status("pushpop4", 3, 1'b1, 1'b1);
    check_head("x6", 32'h00600193, 32'h24, 0, 0, 0, 3'd0, 32'h0, 0, 32'h0);
    step();
    check_status("drain2", 2, 1'b1, 1'b1);
    check_head("x7_jal", 32'h008000EF, 32'h28, 0, 1, 0, 3'd0, 32'h8, 0, 32'h30);
    step();
    check_status("drain1", 1, 1'b1, 1'b1);
    check_head("x8", 32'h00800293, 32'h2C, 0, 0, 0, 3'd0, 32'h0, 0, 32'h0);
    step();
    check_status("drain0", 0, 1'b0, 1'b1);
    step();  // pop request on an empty queue does nothing
    check_status("empty_pop", 0, 1'b0, 1'b1);

    // Legality: zero word, JALR funct3=001, store, B-type funct3=010.
    out_ready_i = 1'b0;
    push_one(32'h00000000, 32'h40);
    push_one(32'h000010E7, 32'h44);
    push_one(32'h0020A023, 32'h48);
    push_one(32'hfe62aee3, 32'h4C);
    out_ready_i = 1'b1;
    check_head("ill_zero", 32'h00000000, 32'h40, 0, 0, 0, 3'd0, 32'h0, 1, 32'h0);
    step();
    check_head("ill_jalr", 32'h000010E7, 32'h44, 0, 0, 1, 3'd0, 32'h0, 1, 32'h0);
    step();
    check_head("store", 32'h0020A023, 32'h48, 0, 0, 0, 3'd0, 32'h0, 0, 32'h0);
    step();
    check_head("ill_br", 32'hfe62aee3, 32'h4C, 1, 0, 0, 3'b010, 32'hFFFFFFFC, 1, 32'h48);
    step();
    check_status("ill_drain", 0, 1'b0, 1'b1);

    // Legal jalr x1,-16(x2): negative I-immediate, no stored target.
    out_ready_i = 1'b0;
    push_one(32'hFF0100E7, 32'h50);
    check_head("jalr", 32'hFF0100E7, 32'h50, 0, 0, 1, 3'd0, 32'hFFFFFFF0, 0, 32'h0);
    out_ready_i = 1'b1;
    step();
    check_status("jalr_pop", 0, 1'b0, 1'b1);

    // Flush with 3 entries held, a push and a pop in the same cycle.
    out_ready_i = 1'b0;
    push_one(32'h00100093, 32'h60);
    push_one(32'h00200093, 32'h64);
    push_one(32'h00300093, 32'h68);
    check_status("pre_flush", 3, 1'b1, 1'b1);
    flush_i     = 1'b1;
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    in_instr_i  = 32'h00900313;
    in_pc_i     = 32'h6C;
    step();
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    check_status("flush", 0, 1'b0, 1'b1);
    push_one(32'h00A00393, 32'h100);
    check_status("post_flush", 1, 1'b1, 1'b1);
    check_head("post_flush", 32'h00A00393, 32'h100, 0, 0, 0, 3'd0, 32'h0, 0, 32'h0);

    // Reset mid-stream with two entries, overriding a same-cycle flush.
    push_one(32'h00B00413, 32'h104);
    check_status("pre_rst", 2, 1'b1, 1'b1);
    rst     = 1'b1;
    flush_i = 1'b1;
    step();
    rst     = 1'b0;
    flush_i = 1'b0;
    check_status("mid_rst", 0, 1'b0, 1'b1);
    push_one(32'h00C00493, 32'h200);
    check_status("post_rst", 1, 1'b1, 1'b1);
    check_head("post_rst", 32'h00C00493, 32'h200, 0, 0, 0, 3'd0, 32'h0, 0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
